// File: rtl/i_cache_if.sv
// IF-side fetch port and mem_ctrl-side miss port of the instruction cache.
// The cache uses the slave view; the fetch stage / memory controller side uses master.
interface i_cache_if;
   localparam int unsigned AddrLen = 32;
   localparam int unsigned InstLen = 32;

   logic               if_req;
   logic [AddrLen-1:0] if_addr;
   logic               flush;
   logic [InstLen-1:0] inst_o;
   logic               inst_valid_o;
   logic               icache_needed;
   logic [AddrLen-1:0] icache_addr;
   logic               inst_available_i;
   logic [InstLen-1:0] inst_i;

   modport slave (
      input  if_req,
      input  if_addr,
      input  flush,
      output inst_o,
      output inst_valid_o,
      output icache_needed,
      output icache_addr,
      input  inst_available_i,
      input  inst_i
   );

   modport master (
      output if_req,
      output if_addr,
      output flush,
      input  inst_o,
      input  inst_valid_o,
      input  icache_needed,
      input  icache_addr,
      output inst_available_i,
      output inst_i
   );
endinterface

// File: rtl/i_cache.sv
// Direct-mapped, one-word-per-line instruction cache; misses are serviced by mem_ctrl
// one word at a time, with flush dropping (but still writing) an in-flight fill.
module i_cache #(
   parameter int unsigned INDEX_BITS = 7
) (
   input logic      clk,
   input logic      rst,
   i_cache_if.slave bus
);
   localparam int unsigned Lines   = 1 << INDEX_BITS;
   localparam int unsigned TagBits = 32 - INDEX_BITS - 2;

   typedef enum logic [0:0] {StIdle, StMiss} state_e;

   state_e                state_q, state_d;
   logic [Lines-1:0]      valid_q, valid_d;
   logic [TagBits-1:0]    tag_q  [Lines];
   logic [31:0]           data_q [Lines];
   logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
   logic [TagBits-1:0]    miss_tag_q, miss_tag_d;
   logic                  drop_q, drop_d;
   logic [31:0]           inst_q, inst_d;
   logic                  inst_valid_q, inst_valid_d;
   logic                  needed_q, needed_d;
   logic [31:0]           miss_addr_q, miss_addr_d;

   logic [INDEX_BITS-1:0] req_idx;
   logic [TagBits-1:0]    req_tag;
   logic                  hit;
   logic                  accept;
   logic                  fill_we;

   assign req_idx = bus.if_addr[INDEX_BITS+1:2];
   assign req_tag = bus.if_addr[31:INDEX_BITS+2];
   assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   // Blocking on inst_valid_q keeps a held if_req from being served twice.
   assign accept  = bus.if_req && !bus.flush && !inst_valid_q;

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      miss_idx_d   = miss_idx_q;
      miss_tag_d   = miss_tag_q;
      drop_d       = drop_q;
      inst_d       = inst_q;
      inst_valid_d = 1'b0;
      needed_d     = needed_q;
      miss_addr_d  = miss_addr_q;
      fill_we      = 1'b0;

      unique case (state_q)
         StIdle: begin
            needed_d = 1'b0;
            drop_d   = 1'b0;
            if (accept) begin
               if (hit) begin
                  inst_d       = data_q[req_idx];
                  inst_valid_d = 1'b1;
               end else begin
                  needed_d    = 1'b1;
                  miss_addr_d = {bus.if_addr[31:2], 2'b00};
                  miss_idx_d  = req_idx;
                  miss_tag_d  = req_tag;
                  state_d     = StMiss;
               end
            end
         end
         StMiss: begin
            needed_d = 1'b1;
            if (bus.flush) begin
               drop_d = 1'b1;
            end
            // The transfer cannot be aborted, so a flushed fill is still written.
            if (bus.inst_available_i) begin
               fill_we             = 1'b1;
               valid_d[miss_idx_q] = 1'b1;
               needed_d            = 1'b0;
               drop_d              = 1'b0;
               state_d             = StIdle;
               if (!drop_q && !bus.flush) begin
                  inst_d       = bus.inst_i;
                  inst_valid_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         valid_q      <= '0;
         miss_idx_q   <= '0;
         miss_tag_q   <= '0;
         drop_q       <= 1'b0;
         inst_q       <= '0;
         inst_valid_q <= 1'b0;
         needed_q     <= 1'b0;
         miss_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         miss_idx_q   <= miss_idx_d;
         miss_tag_q   <= miss_tag_d;
         drop_q       <= drop_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         needed_q     <= needed_d;
         miss_addr_q  <= miss_addr_d;
      end
   end

   // Tag/data need no reset: the valid bits gate every read.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[miss_idx_q]  <= miss_tag_q;
         data_q[miss_idx_q] <= bus.inst_i;
      end
   end

   assign bus.inst_o        = inst_q;
   assign bus.inst_valid_o  = inst_valid_q;
   assign bus.icache_needed = needed_q;
   assign bus.icache_addr   = miss_addr_q;
endmodule

// File: tb/tb_i_cache.sv
// Bench for i_cache: directed cases then random fetches, checked against an array model
// of valid/tag/data indexed by address arithmetic.
module tb_i_cache;
   localparam int unsigned IndexBits = 7;
   localparam int unsigned Lines     = 1 << IndexBits;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   bit          m_valid [Lines];
   int unsigned m_tag   [Lines];
   logic [31:0] m_data  [Lines];

   i_cache_if bus ();

   i_cache #(.INDEX_BITS(IndexBits)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", nm, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < int'(Lines); i++) m_valid[i] = 1'b0;
   endtask

   task automatic model_fill(input logic [31:0] addr, input logic [31:0] d);
      int unsigned idx;
      idx          = (addr >> 2) % Lines;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = addr >> (IndexBits + 2);
      m_data[idx]  = d;
   endtask

   // One complete fetch; hit or miss is decided by the model.
   task automatic fetch(input logic [31:0] addr, input int unsigned lat, input logic [31:0] fill,
                        input string nm);
      int unsigned idx;
      int unsigned tg;
      bit          hit;
      idx = (addr >> 2) % Lines;
      tg  = addr >> (IndexBits + 2);
      hit = m_valid[idx] && (m_tag[idx] == tg);
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
      @(posedge clk); #1;
      if (hit) begin
         chk({nm, " hit valid"}, bus.inst_valid_o, 1);
         chk({nm, " hit data"}, bus.inst_o, m_data[idx]);
         chk({nm, " hit needed"}, bus.icache_needed, 0);
      end else begin
         chk({nm, " miss needed"}, bus.icache_needed, 1);
         chk({nm, " miss addr"}, bus.icache_addr, addr & ~32'h3);
         chk({nm, " miss valid"}, bus.inst_valid_o, 0);
         repeat (lat) begin
            @(posedge clk); #1;
            chk({nm, " miss hold"}, bus.icache_needed, 1);
         end
         @(negedge clk);
         bus.inst_available_i = 1'b1;
         bus.inst_i           = fill;
         @(posedge clk); #1;
         chk({nm, " fill valid"}, bus.inst_valid_o, 1);
         chk({nm, " fill data"}, bus.inst_o, fill);
         chk({nm, " fill needed"}, bus.icache_needed, 0);
         model_fill(addr, fill);
      end
      @(negedge clk);
      bus.if_req           = 1'b0;
      bus.inst_available_i = 1'b0;
      @(posedge clk); #1;
      chk({nm, " pulse width"}, bus.inst_valid_o, 0);
      chk({nm, " idle needed"}, bus.icache_needed, 0);
   endtask

   initial begin
      logic [31:0] a;
      total                = 0;
      bad                  = 0;
      rst                  = 1'b0;
      bus.if_req           = 1'b0;
      bus.if_addr          = '0;
      bus.flush            = 1'b0;
      bus.inst_available_i = 1'b0;
      bus.inst_i           = '0;
      model_clear();

      #3;
      chk("reset inst_o", bus.inst_o, 0);
      chk("reset valid", bus.inst_valid_o, 0);
      chk("reset needed", bus.icache_needed, 0);
      chk("reset addr", bus.icache_addr, 0);
      @(negedge clk);
      rst = 1'b1;

      fetch(32'h0000_0000, 3, 32'h0000_0013, "cold");
      fetch(32'h0000_0000, 0, 32'h0, "rehit");
      fetch(32'h0000_0004, 2, 32'h1111_1111, "fill4");
      fetch(32'h0000_0204, 1, 32'h2222_2222, "conflict");
      fetch(32'h0000_0004, 1, 32'h1111_1111, "evicted");
      fetch(32'h0000_0006, 0, 32'h0, "unaligned");

      // Flush during miss: fill is written but not delivered.
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0100;
      @(posedge clk); #1;
      chk("flushmiss needed", bus.icache_needed, 1);
      chk("flushmiss addr", bus.icache_addr, 32'h0000_0100);
      @(negedge clk);
      @(negedge clk);
      bus.flush  = 1'b1;
      bus.if_req = 1'b0;
      @(negedge clk);
      bus.flush = 1'b0;
      @(negedge clk);
      bus.inst_available_i = 1'b1;
      bus.inst_i           = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      chk("flushmiss no valid", bus.inst_valid_o, 0);
      chk("flushmiss needed low", bus.icache_needed, 0);
      model_fill(32'h0000_0100, 32'hDEAD_BEEF);
      @(negedge clk);
      bus.inst_available_i = 1'b0;
      @(posedge clk); #1;
      chk("flushmiss still no valid", bus.inst_valid_o, 0);
      fetch(32'h0000_0100, 0, 32'h0, "after flush");

      // Flush on the same edge as the fill.
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0300;
      @(posedge clk); #1;
      chk("flushfill needed", bus.icache_needed, 1);
      @(negedge clk);
      bus.if_req           = 1'b0;
      bus.flush            = 1'b1;
      bus.inst_available_i = 1'b1;
      bus.inst_i           = 32'hCAFE_F00D;
      @(posedge clk); #1;
      chk("flushfill no valid", bus.inst_valid_o, 0);
      chk("flushfill needed low", bus.icache_needed, 0);
      model_fill(32'h0000_0300, 32'hCAFE_F00D);
      @(negedge clk);
      bus.flush            = 1'b0;
      bus.inst_available_i = 1'b0;
      fetch(32'h0000_0300, 0, 32'h0, "after flushfill");

      // Flush in idle blocks acceptance of a hitting request.
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0100;
      bus.flush   = 1'b1;
      @(posedge clk); #1;
      chk("idle flush valid", bus.inst_valid_o, 0);
      chk("idle flush needed", bus.icache_needed, 0);
      @(negedge clk);
      bus.if_req = 1'b0;
      bus.flush  = 1'b0;

      // Stray fill pulse in idle is ignored.
      @(negedge clk);
      bus.inst_available_i = 1'b1;
      bus.inst_i           = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      chk("idle avail valid", bus.inst_valid_o, 0);
      @(negedge clk);
      bus.inst_available_i = 1'b0;
      fetch(32'h0000_0004, 0, 32'h0, "after stray");

      for (int i = 0; i < 60; i++) begin
         a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         fetch(a, $urandom_range(0, 3), $urandom, "rand");
      end

      // Asynchronous reset in the middle of a miss.
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0040;
      @(posedge clk); #1;
      chk("rstmiss needed", bus.icache_needed, 1);
      @(negedge clk);
      #2;
      rst        = 1'b0;
      bus.if_req = 1'b0;
      #1;
      chk("async rst needed", bus.icache_needed, 0);
      chk("async rst valid", bus.inst_valid_o, 0);
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      fetch(32'h0000_0000, 2, 32'h0000_0013, "post reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/i_cache.md
# i_cache

Direct-mapped, word-granular instruction cache between the IF stage and `mem_ctrl`. It serves IF fetches from an on-chip array. On a miss it acts as the requester on the `mem_ctrl` instruction port: it asserts `icache_needed`/`icache_addr` and waits for `mem_ctrl` to return one 32-bit word. It then fills the line and delivers the word to IF.

## Interface
- `INDEX_BITS`, default 7, number of index bits; the array holds 2^INDEX_BITS one-word lines.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  IF fetch request; held until `inst_valid_o` or `flush`.
- `if_addr`  in  `AddrLen` (32)  fetch PC; stable while `if_req` is high; bits [1:0] are ignored.
- `flush`  in  1  cancels the outstanding fetch (branch redirect).
- `inst_o`  out  `InstLen` (32)  instruction returned to IF.
- `inst_valid_o`  out  1  one-cycle pulse; `inst_o` is valid.
- `icache_needed`  out  1  miss request to `mem_ctrl`; level signal.
- `icache_addr`  out  `AddrLen`  word-aligned miss address to `mem_ctrl`.
- `inst_available_i`  in  1  `mem_ctrl` fill-done pulse.
- `inst_i`  in  `InstLen`  fill word from `mem_ctrl`; sampled when `inst_available_i` is high.

## Operation
- Address split:
  - index = `if_addr[INDEX_BITS+1:2]`
  - tag = `if_addr[31:INDEX_BITS+2]`
- Per-line storage: valid bit, tag, 32-bit data.
- Hit condition: valid[index] is set and the stored tag equals the request tag.
- State machine:
  - IDLE: a request is accepted on an edge where `if_req`=1, `flush`=0 and `inst_valid_o`=0.
    - On a hit, the next cycle has `inst_o`=data and `inst_valid_o`=1; the block stays in IDLE.
    - On a miss, the next cycle has `icache_needed`=1 and `icache_addr`={`if_addr[31:2]`,2'b00}; the block moves to MISS and latches the index and tag.
  - MISS: `icache_needed` and `icache_addr` are held until the edge that samples `inst_available_i`=1. On that edge:
    - the line is written: valid=1, latched tag, `inst_i`;
    - `icache_needed` is cleared;
    - `inst_o`=`inst_i` and `inst_valid_o`=1 in the next cycle, unless the drop flag is set;
    - the block returns to IDLE.
  - `inst_available_i` is ignored in IDLE.
- Flush:
  - `flush` in IDLE: no request is accepted that cycle, and `inst_valid_o` is forced to 0 in the next cycle.
  - `flush` in MISS: sets the drop flag. A `mem_ctrl` transfer cannot be aborted, so the fill still completes and is still written, but `inst_valid_o` stays 0. The drop flag is cleared on return to IDLE.
  - `flush` and `inst_available_i` on the same edge in MISS: the line is written, nothing is delivered, and the block goes to IDLE.
  - `flush` never invalidates array contents.
- The block has no write or invalidate path. Instruction memory is read-only from this block's view.

## Timing
- Reset (asynchronous, with no clock required):
  - `inst_o`=0, `inst_valid_o`=0, `icache_needed`=0, `icache_addr`=0
  - state = IDLE, drop flag = 0, every valid bit = 0
- Reset asserted mid-miss: `icache_needed` drops immediately. `mem_ctrl` is reset by the same signal, and the in-flight fill is lost.
- Hit latency is 1 cycle from the accepting edge. Because acceptance is blocked while `inst_valid_o`=1, hit throughput is one instruction per 2 cycles.
- Miss latency is 1 + N + 1 cycles, where N is the `mem_ctrl` service time in cycles. `icache_needed` is low in the cycle after the fill edge.
- `inst_valid_o` is always exactly one cycle wide.

## Test plan
- Cold miss: reset, then `if_req` with `if_addr`=0x00000000.
  - Required: `icache_needed`=1 and `icache_addr`=0x00000000 one cycle later.
  - Drive `inst_available_i`=1 with `inst_i`=0x00000013 four cycles later. Required: `inst_valid_o` pulses once the next cycle with `inst_o`=0x00000013, and `icache_needed`=0.
- Hit: re-request 0x00000000. Required: `inst_valid_o` one cycle after acceptance with 0x00000013, and `icache_needed` never rises.
- Conflict (INDEX_BITS=7): fill 0x00000004 with 0x11111111, then request 0x00000204 (same index 1, different tag).
  - Required: 0x00000204 misses with `icache_addr`=0x00000204; fill it with 0x22222222.
  - Then request 0x00000004. Required: it misses again.
- Flush during miss: request 0x00000100; assert `flush` 2 cycles later; fill 0xDEADBEEF.
  - Required: no `inst_valid_o` pulse for that fill.
  - A later request to 0x00000100 hits and returns 0xDEADBEEF.
- Unaligned address: after 0x00000004 has been filled, request 0x00000006. Required: a hit returning the 0x00000004 data. If the line is cold instead, required `icache_addr`=0x00000004.
- Asynchronous reset mid-miss: pull `rst` low between clock edges during MISS.
  - Required: `icache_needed`=0 and `inst_valid_o`=0 immediately.
  - After release, a request to 0x00000000 misses again.
